// File: rtl/quad_dec_up_down.sv
// Quadrature A/B decoder: synchronises and glitch-filters two encoder phases, decodes Gray
// steps into a one-cycle strobe with direction, and keeps a wrapping position count.
module quad_dec_up_down #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 3,
  parameter int unsigned WIDTH       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             err_clr,
  output logic             step,
  output logic             up_down,
  output logic [WIDTH-1:0] pos,
  output logic             err
);

  localparam int unsigned FCW = $clog2(FILT_CYCLES + 1);
  localparam int unsigned ICW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [0:0] {StInit, StTrack} state_e;

  state_e                 state_q;
  logic [ICW-1:0]         init_cnt_q;
  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [1:0]             raw;       // {a, b} after synchronisers
  logic [1:0]             filt_q;    // {a_f, b_f}
  logic [FCW-1:0]         cnt_q [2];
  logic [1:0]             prev_q;
  logic                   init_load;
  logic                   is_up, is_down, is_illegal;

  assign raw       = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign init_load = (state_q == StInit) && (init_cnt_q == ICW'(SYNC_STAGES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
    end
  end

  // A filtered level flips only after the synced value has disagreed with it on
  // FILT_CYCLES+1 consecutive edges; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (init_load) begin
          filt_q[i] <= raw[i];
          cnt_q[i]  <= '0;
        end else if (state_q == StInit || raw[i] == filt_q[i]) begin
          cnt_q[i]  <= '0;
        end else if (cnt_q[i] == FCW'(FILT_CYCLES)) begin
          filt_q[i] <= raw[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i]  <= cnt_q[i] + FCW'(1);
        end
      end
    end
  end

  always_comb begin
    is_up      = 1'b0;
    is_down    = 1'b0;
    is_illegal = 1'b0;
    case ({prev_q, filt_q})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_up      = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: is_down    = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: is_illegal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      prev_q     <= '0;
      step       <= 1'b0;
      up_down    <= 1'b0;
      pos        <= '0;
      err        <= 1'b0;
    end else begin
      step <= 1'b0;
      unique case (state_q)
        StInit: begin
          if (init_load) begin
            state_q <= StTrack;
            prev_q  <= raw;
          end else begin
            init_cnt_q <= init_cnt_q + ICW'(1);
          end
        end
        StTrack: begin
          // prev tracks even when disabled so re-enabling never replays old motion
          prev_q <= filt_q;
          if (enable) begin
            if (is_up) begin
              step    <= 1'b1;
              up_down <= 1'b1;
              pos     <= pos + WIDTH'(1);
            end else if (is_down) begin
              step    <= 1'b1;
              up_down <= 1'b0;
              pos     <= pos - WIDTH'(1);
            end
            if (is_illegal) begin
              err <= 1'b1;
            end else if (err_clr) begin
              err <= 1'b0;
            end
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule
